// File: rtl/seq_controller.sv
// Fetch/decode/execute sequencer with memory handshake, sticky halt and retired-instruction counter.
// Optional single-step mode is compiled in with the SEQ_STEP_EN macro.
module seq_controller #(
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             halt,
    input  logic             mem_ack,
`ifdef SEQ_STEP_EN
    input  logic             step,
`endif
    output logic [2:0]       cs,
    output logic             mem_req,
    output logic             busy,
    output logic             exec_done,
    output logic [CNT_W-1:0] icount
);

    localparam int ECW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_FETCH  = 3'b001,
        S_WAIT   = 3'b010,
        S_DECODE = 3'b011,
        S_EXEC   = 3'b100
    } state_t;

    state_t         state, ns;
    logic [ECW-1:0] exec_cnt, exec_cnt_n;
    logic           halt_pend, halt_pend_n;
    logic           retire;
    logic           stop_req;

`ifdef SEQ_STEP_EN
    assign stop_req = halt_pend | halt | step;
`else
    assign stop_req = halt_pend | halt;
`endif

    always_comb begin
        ns         = state;
        exec_cnt_n = exec_cnt;
        retire     = 1'b0;
        case (state)
            S_IDLE:   if (run && !halt) ns = S_FETCH;
            S_FETCH:  ns = mem_ack ? S_DECODE : S_WAIT;
            S_WAIT:   if (mem_ack) ns = S_DECODE;
            S_DECODE: begin
                ns         = S_EXEC;
                exec_cnt_n = ECW'(EXEC_CYCLES - 1);
            end
            S_EXEC: begin
                if (exec_cnt != '0) begin
                    exec_cnt_n = exec_cnt - 1'b1;
                end else begin
                    retire = 1'b1;
                    ns     = stop_req ? S_IDLE : S_FETCH;
                end
            end
            default:  ns = S_IDLE;
        endcase
        // A halt seen while busy is remembered until the sequencer parks in IDLE.
        halt_pend_n = (ns == S_IDLE) ? 1'b0 : (halt_pend | (halt && (state != S_IDLE)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            exec_cnt  <= '0;
            halt_pend <= 1'b0;
            exec_done <= 1'b0;
            icount    <= '0;
        end else begin
            state     <= ns;
            exec_cnt  <= exec_cnt_n;
            halt_pend <= halt_pend_n;
            exec_done <= retire;
            if (retire) icount <= icount + 1'b1;
        end
    end

    assign cs      = state;
    assign mem_req = (state == S_FETCH) || (state == S_WAIT);
    assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_seq_controller.sv
// Bench for seq_controller: directed scenarios plus random run/halt/ack traffic against an
// instruction-level reference model (fetch length, decode, exec cycle count, sticky halt).
module tb_seq_controller;
    localparam int EC = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          run = 1'b0;
    logic          halt = 1'b0;
    logic          mem_ack = 1'b0;
`ifdef SEQ_STEP_EN
    logic          step = 1'b0;
`endif
    logic [2:0]    cs;
    logic          mem_req, busy, exec_done;
    logic [CW-1:0] icount;

    int checks = 0;
    int errors = 0;

    // reference model: phase 0 idle, 1 fetching, 2 decode, 3 executing
    int ph, fcnt, ecnt, icnt;
    bit hp, done;

    seq_controller #(.EXEC_CYCLES(EC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .run(run), .halt(halt), .mem_ack(mem_ack),
`ifdef SEQ_STEP_EN
        .step(step),
`endif
        .cs(cs), .mem_req(mem_req), .busy(busy), .exec_done(exec_done), .icount(icount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        ph = 0; fcnt = 0; ecnt = 0; icnt = 0; hp = 0; done = 0;
    endtask

    task automatic model_step();
        int  old_ph;
        bit  stop;
        old_ph = ph;
        done   = 0;
        if (!reset) begin
            reset_model();
            return;
        end
        stop = hp || halt;
`ifdef SEQ_STEP_EN
        stop = stop || step;
`endif
        case (ph)
            0: if (run && !halt) begin ph = 1; fcnt = 0; end
            1: if (mem_ack) ph = 2; else fcnt++;
            2: begin ph = 3; ecnt = 0; end
            default: begin
                if (ecnt == EC - 1) begin
                    icnt = (icnt + 1) % (1 << CW);
                    done = 1;
                    if (stop) ph = 0; else begin ph = 1; fcnt = 0; end
                end else ecnt++;
            end
        endcase
        if (ph == 0) hp = 0;
        else if (old_ph != 0 && halt) hp = 1;
    endtask

    function automatic logic [2:0] exp_cs();
        case (ph)
            0: return 3'b000;
            1: return (fcnt == 0) ? 3'b001 : 3'b010;
            2: return 3'b011;
            default: return 3'b100;
        endcase
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".cs"}, cs, exp_cs());
        chk({tag, ".mem_req"}, mem_req, (ph == 1));
        chk({tag, ".busy"}, busy, (ph != 0));
        chk({tag, ".exec_done"}, exec_done, done);
        chk({tag, ".icount"}, icount, icnt);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        reset_model();
        #3;
        check_all("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle("post_reset");

        // back-to-back instructions with immediate ack
        run = 1'b1; mem_ack = 1'b1;
        cycle("t1_start");
        run = 1'b0;
        repeat (12) cycle("t1_stream");

        // halt pulsed in DECODE: current instruction retires, then IDLE
        for (int i = 0; i < 20 && ph != 2; i++) cycle("t3_seek");
        halt = 1'b1;
        cycle("t3_halt");
        halt = 1'b0;
        repeat (6) cycle("t3_drain");
        chk("t3_idle_busy", busy, 1'b0);

        // run together with halt in IDLE is ignored
        run = 1'b1; halt = 1'b1;
        cycle("t4_a");
        cycle("t4_b");
        chk("t4_no_req", mem_req, 1'b0);
        halt = 1'b0;
        cycle("t3_restart");
        run = 1'b0;

        // delayed ack and counter wrap
        for (int i = 0; i < 60; i++) begin
            mem_ack = (i % 3 == 2);
            cycle("wait_ack");
        end
        mem_ack = 1'b1;
        repeat (90) cycle("wrap");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            run     = ($urandom_range(0, 3) == 0);
            halt    = ($urandom_range(0, 15) == 0);
            mem_ack = ($urandom_range(0, 2) == 0);
            cycle("rand");
        end

        // async reset while waiting on memory
        halt = 1'b0; mem_ack = 1'b0; run = 1'b1;
        for (int i = 0; i < 30 && !(ph == 1 && fcnt > 0); i++) cycle("t6_seek");
        chk("t6_in_wait", cs, 3'b010);
        run = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        reset_model();
        check_all("t6_async");
        cycle("t6_held");
        reset = 1'b1;
        mem_ack = 1'b1;
        repeat (4) cycle("t6_after");
        run = 1'b1;
        cycle("t6_rerun");
        run = 1'b0;
        repeat (10) cycle("t6_tail");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
